// File: rtl/wb_retire.sv
// Writeback/retire stage: accepts NRET retire lanes per cycle, registers regfile
// writes with one cycle of latency, counts retired instructions, resolves
// same-group write conflicts and sequences the exit -> drain -> halt shutdown.
module wb_retire #(
  parameter int XLEN         = 64,
  parameter int NRET         = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRET-1:0]      valid_i,
  input  logic [NRET-1:0]      wen_i,
  input  logic [NRET*5-1:0]    rd_i,
  input  logic [NRET*XLEN-1:0] wdata_i,
  input  logic [NRET*XLEN-1:0] pc_i,
  input  logic [NRET-1:0]      exit_i,
  input  logic [XLEN-1:0]      a0_i,
  output logic [NRET-1:0]      wen_o,
  output logic [NRET*5-1:0]    rd_o,
  output logic [NRET*XLEN-1:0] wdata_o,
  output logic [CNT_W-1:0]     instret_o,
  output logic                 halt_o,
  output logic [XLEN-1:0]      exit_code_o,
  output logic [XLEN-1:0]      exit_pc_o,
  output logic                 good_trap_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Drain counter starts at DRAIN_CYCLES-1 so that HALT is reached after exactly
  // DRAIN_CYCLES cycles spent in DRAIN.
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  state_t            state_r;
  logic [31:0]       drain_cnt_r;

  logic              any_exit_s;
  logic [2:0]        exit_idx_s;
  logic [NRET-1:0]   acc_s;
  logic [NRET-1:0]   qual_s;
  logic [NRET-1:0]   wen_s;
  logic [XLEN-1:0]   code_s;
  logic [XLEN-1:0]   pc_s;

  // Number of set bits in a lane mask, widened to the counter width.
  function automatic logic [CNT_W-1:0] popcount(input logic [NRET-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int k = 0; k < NRET; k++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Locate the oldest valid exit lane; scanning young-to-old lets the oldest win.
  always_comb begin
    any_exit_s = 1'b0;
    exit_idx_s = 3'd0;
    for (int k = NRET - 1; k >= 0; k--) begin
      if (valid_i[k] && exit_i[k]) begin
        any_exit_s = 1'b1;
        exit_idx_s = 3'(k);
      end else begin
        exit_idx_s = exit_idx_s;
      end
    end
  end

  // Lanes younger than the exit are killed; surviving writes to x0 are dropped.
  always_comb begin
    acc_s  = {NRET{1'b0}};
    qual_s = {NRET{1'b0}};
    for (int k = 0; k < NRET; k++) begin
      acc_s[k]  = valid_i[k] && (!any_exit_s || (3'(k) <= exit_idx_s));
      qual_s[k] = acc_s[k] && wen_i[k] && (rd_i[5*k +: 5] != 5'd0);
    end
  end

  // Same-group WAW: an older lane loses its write if any younger lane targets the same rd.
  always_comb begin
    wen_s = qual_s;
    for (int j = 0; j < NRET; j++) begin
      for (int k = j + 1; k < NRET; k++) begin
        if (qual_s[k] && (rd_i[5*k +: 5] == rd_i[5*j +: 5])) begin
          wen_s[j] = 1'b0;
        end else begin
          wen_s[j] = wen_s[j];
        end
      end
    end
  end

  // Exit code is the youngest surviving write to a0 in the group, else the incoming a0.
  always_comb begin
    code_s = a0_i;
    pc_s   = {XLEN{1'b0}};
    for (int k = 0; k < NRET; k++) begin
      if (qual_s[k] && (rd_i[5*k +: 5] == 5'd10)) begin
        code_s = wdata_i[XLEN*k +: XLEN];
      end else begin
        code_s = code_s;
      end
      if (3'(k) == exit_idx_s) begin
        pc_s = pc_i[XLEN*k +: XLEN];
      end else begin
        pc_s = pc_s;
      end
    end
  end

  // Retire FSM with registered writeback, instret counter and sticky exit status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= 32'd0;
      wen_o       <= {NRET{1'b0}};
      rd_o        <= {(NRET*5){1'b0}};
      wdata_o     <= {(NRET*XLEN){1'b0}};
      instret_o   <= {CNT_W{1'b0}};
      halt_o      <= 1'b0;
      exit_code_o <= {XLEN{1'b0}};
      exit_pc_o   <= {XLEN{1'b0}};
      good_trap_o <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          wen_o     <= wen_s;
          rd_o      <= rd_i;
          wdata_o   <= wdata_i;
          instret_o <= instret_o + popcount(acc_s);
          if (any_exit_s) begin
            exit_pc_o   <= pc_s;
            exit_code_o <= code_s;
            if (DRAIN_CYCLES == 0) begin
              state_r     <= ST_HALT;
              halt_o      <= 1'b1;
              good_trap_o <= (code_s == {XLEN{1'b0}});
            end else begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= DRAIN_LOAD;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          wen_o <= {NRET{1'b0}};
          if (drain_cnt_r == 32'd0) begin
            state_r     <= ST_HALT;
            halt_o      <= 1'b1;
            good_trap_o <= (exit_code_o == {XLEN{1'b0}});
          end else begin
            drain_cnt_r <= drain_cnt_r - 32'd1;
          end
        end
        ST_HALT: begin
          wen_o <= {NRET{1'b0}};
        end
        default: begin
          state_r <= ST_RUN;
          wen_o   <= {NRET{1'b0}};
        end
      endcase
    end
  end

endmodule
